iter_cmp_unit: RTL and testbench
================================

# iter_cmp_unit

Parametrised, multi-cycle successor to the single-cycle branch comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, with early termination on the first differing chunk. Supports every `CorePack::cmp_op_enum` operation. Sits between the operand-read stage and branch resolution for wide-operand or area-constrained configurations, with valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 64: operand width. Must be a multiple of `CHUNK`.
- `CHUNK`, default 16: bits compared per cycle. N = WIDTH/CHUNK chunks; N = 1 is legal.
- `clk` input 1: clock.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `in_valid` input 1: request present.
- `in_ready` output 1: unit can accept a request. High only in IDLE.
- `a` input WIDTH: operand A, sampled on acceptance.
- `b` input WIDTH: operand B, sampled on acceptance.
- `cmp_op` input `cmp_op_enum` (3 bits): operation, sampled on acceptance.
- `out_valid` output 1: `cmp_res` is valid.
- `out_ready` input 1: consumer takes the result.
- `cmp_res` output 1: comparison result.

## Operation
- States: IDLE, SCAN, DONE.
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `cmp_res`=0, chunk index 0.
- IDLE:
  - `in_valid`&&`in_ready` at an edge latches `a`, `b` and `cmp_op`.
  - For CMP_LT and CMP_GE, the MSB of both latched operands is inverted. Signed compare then reduces to unsigned.
  - CMP_NO and CMP7 go directly to DONE with result 0.
  - All other ops go to SCAN with index 0, which addresses the MSB chunk.
- SCAN:
  - Each cycle compares chunk [WIDTH-1-i*CHUNK -: CHUNK] of the latched operands unsigned, producing eq and lt.
  - If the chunk differs, or i = N-1, register the result and go to DONE.
  - Otherwise increment i.
- Result mapping, where eq means all scanned chunks are equal and lt is taken from the first differing chunk:
  - EQ → eq.
  - NE → !eq.
  - LT / LTU → lt.
  - GE / GEU → !lt.
- DONE:
  - `out_valid`=1.
  - `cmp_res` is held stable until `out_valid`&&`out_ready` at an edge, then go to IDLE.
  - No input is accepted in DONE or SCAN.
- `rst` in any state aborts the operation at the next edge:
  - No result is produced.
  - All outputs return to their reset values.

## Timing
- Request accepted at edge ending cycle T.
- CMP_NO / CMP7: `out_valid` high in cycle T+1.
- Other ops: `out_valid` high in cycle T+1+k. k ∈ [1,N] is the index of the first differing chunk plus 1, or N if all chunks are equal. Maximum latency is N+1.
- With `out_ready` held high, DONE lasts 1 cycle. Next acceptance is possible no earlier than the cycle after DONE, so `in_ready` is low for L cycles after acceptance.
- Registered outputs: `out_valid`, `cmp_res`. `in_ready` is decoded from state.
- Chunk index width: max(1, $clog2(N)). The index never wraps; it resets to 0 on acceptance.

## Structure
- `CorePack` keeps `cmp_op_enum` unchanged.
- Add `iter_cmp_state_enum` {IDLE, SCAN, DONE} to `CorePack`.
- One sub-module: `cmp_chunk`, parametrised on `CHUNK`, combinational unsigned eq/lt of two chunks. Instantiated once and fed by an index mux.
- Elaboration-time check: WIDTH % CHUNK == 0.

## Test plan
All scenarios use WIDTH=64, CHUNK=16.
- CMP_LT, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, `out_ready`=1 → `cmp_res`=1, `out_valid` in cycle T+2.
- CMP_LTU, same operands → `cmp_res`=0, `out_valid` in cycle T+2.
- CMP_EQ, a=b=0x1234_5678_9ABC_DEF0 → `cmp_res`=1 in cycle T+5. CMP_NE with the same operands → 0 in cycle T+5.
- CMP_GEU, a=0x...0001, b=0x...0002 (differing only in the lowest chunk), `out_ready` low for 3 cycles → `cmp_res`=0 first valid in cycle T+5. `out_valid`, `cmp_res` stable and `in_ready`=0 throughout the stall.
- CMP_NO and CMP7, arbitrary operands → `cmp_res`=0, `out_valid` in cycle T+1.
- CMP_GE with `rst` pulsed during SCAN after 2 chunks → next cycle `out_valid`=0, `in_ready`=1, `cmp_res`=0. A following CMP_GE with a=5, b=-3 → `cmp_res`=1.

Source files
------------

// File: rtl/iter_cmp_unit_pkg.sv
// Shared core types: comparison opcodes, iterative comparator states and
// the eq/lt to branch-result mapping.
package CorePack;

   typedef enum logic [2:0] {
      CMP_NO  = 3'd0,
      CMP_EQ  = 3'd1,
      CMP_NE  = 3'd2,
      CMP_LT  = 3'd3,
      CMP_GE  = 3'd4,
      CMP_LTU = 3'd5,
      CMP_GEU = 3'd6,
      CMP7    = 3'd7
   } cmp_op_enum;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } iter_cmp_state_enum;

   // eq covers all chunks scanned so far; lt comes from the first differing chunk.
   function automatic logic map_result(cmp_op_enum op, logic eq, logic lt);
      logic res;
      res = 1'b0;
      case (op)
         CMP_EQ:           res = eq;
         CMP_NE:           res = !eq;
         CMP_LT, CMP_LTU:  res = lt;
         CMP_GE, CMP_GEU:  res = !lt;
         default:          res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/iter_cmp_unit_cmp_chunk.sv
// Combinational unsigned equality / less-than of one operand chunk.
module cmp_chunk #(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a_chunk,
   input  logic [CHUNK-1:0] b_chunk,
   output logic             eq,
   output logic             lt
);

   assign eq = (a_chunk == b_chunk);
   assign lt = (a_chunk <  b_chunk);

endmodule

// File: rtl/iter_cmp_unit.sv
// Multi-cycle branch comparator: scans operands CHUNK bits per cycle from the
// MSB end, stopping at the first differing chunk.
module iter_cmp_unit
   import CorePack::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  cmp_op_enum       cmp_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             cmp_res
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_width
         $error("iter_cmp_unit: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   iter_cmp_state_enum state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   cmp_op_enum         op_q, op_d;
   logic               out_valid_q, out_valid_d;
   logic               cmp_res_q, cmp_res_d;

   logic [CHUNK-1:0]   a_chunks [N];
   logic [CHUNK-1:0]   b_chunks [N];
   logic [CHUNK-1:0]   a_sel, b_sel;
   logic               chunk_eq, chunk_lt;

   // Chunk 0 is the most significant slice.
   for (genvar g = 0; g < N; g++) begin : g_chunks
      assign a_chunks[g] = a_q[WIDTH-1-g*CHUNK -: CHUNK];
      assign b_chunks[g] = b_q[WIDTH-1-g*CHUNK -: CHUNK];
   end

   assign a_sel = a_chunks[idx_q];
   assign b_sel = b_chunks[idx_q];

   cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
      .a_chunk (a_sel),
      .b_chunk (b_sel),
      .eq      (chunk_eq),
      .lt      (chunk_lt)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      out_valid_d = out_valid_q;
      cmp_res_d   = cmp_res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d   = a;
               b_d   = b;
               op_d  = cmp_op;
               idx_d = '0;
               // Flipping both sign bits turns a signed compare into an unsigned one.
               if (cmp_op == CMP_LT || cmp_op == CMP_GE) begin
                  a_d = a ^ MSB_MASK;
                  b_d = b ^ MSB_MASK;
               end
               if (cmp_op == CMP_NO || cmp_op == CMP7) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  cmp_res_d   = 1'b0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (!chunk_eq || idx_q == IDX_LAST) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               cmp_res_d   = map_result(op_q, chunk_eq, chunk_lt);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         cmp_res_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         cmp_res_q   <= cmp_res_d;
      end
   end

   // Operand and opcode holding registers carry no reset; they are only
   // read while a request is in flight.
   always_ff @(posedge clk) begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign cmp_res   = cmp_res_q;

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Directed bench for iter_cmp_unit at WIDTH=64, CHUNK=16.
module tb_iter_cmp_unit;
   import CorePack::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a;
   logic [63:0] b;
   cmp_op_enum  cmp_op;
   logic        out_valid;
   logic        out_ready;
   logic        cmp_res;

   int checks   = 0;
   int failures = 0;
   int lat;

   iter_cmp_unit #(.WIDTH(64), .CHUNK(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cmp_op    (cmp_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cmp_res   (cmp_res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request, checks it is accepted, then counts cycles until out_valid.
   task automatic issue(input cmp_op_enum op, input logic [63:0] av, input logic [63:0] bv);
      chk("in_ready_before_req", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      cmp_op   = op;
      a        = av;
      b        = bv;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic run(input string tag, input cmp_op_enum op, input logic [63:0] av,
                      input logic [63:0] bv, input int exp_lat, input logic exp_res);
      issue(op, av, bv);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, 32'(cmp_res), 32'(exp_res));
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
      chk({tag, "_released"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      cmp_op    = CMP_NO;
      tick();
      tick();
      rst = 1'b0;
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_cmp_res", 32'(cmp_res), 32'd0);

      // -1 < 1 signed, decided in the MSB chunk.
      run("lt_signed", CMP_LT, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2, 1'b1);
      run("ltu_unsigned", CMP_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2, 1'b0);
      run("eq_equal", CMP_EQ, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 5, 1'b1);
      run("ne_equal", CMP_NE, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 5, 1'b0);

      // Result stall: out_ready low for 3 cycles.
      out_ready = 1'b0;
      issue(CMP_GEU, 64'h1, 64'h2);
      chk("geu_latency", 32'(lat), 32'd5);
      chk("geu_res", 32'(cmp_res), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_out_valid", 32'(out_valid), 32'd1);
         chk("stall_cmp_res", 32'(cmp_res), 32'd0);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      chk("stall_released", 32'(out_valid), 32'd0);
      chk("stall_in_ready_after", 32'(in_ready), 32'd1);

      run("cmp_no", CMP_NO, 64'hABCD, 64'hABCD, 1, 1'b0);
      run("cmp7", CMP7, 64'h5555, 64'h5555, 1, 1'b0);

      // Leaves cmp_res at 1 so the reset abort below is observable.
      run("geu_true", CMP_GEU, 64'h5, 64'h3, 5, 1'b1);

      // Reset after two chunks of an all-equal scan.
      chk("pre_abort_res", 32'(cmp_res), 32'd1);
      in_valid = 1'b1;
      cmp_op   = CMP_GE;
      a        = 64'h0000_0000_0000_0007;
      b        = 64'h0000_0000_0000_0007;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("abort_scanning", 32'(in_ready), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_cmp_res", 32'(cmp_res), 32'd0);
      tick();
      tick();
      chk("abort_no_result", 32'(out_valid), 32'd0);

      // 5 >= -3 signed.
      run("ge_signed", CMP_GE, 64'h5, 64'hFFFF_FFFF_FFFF_FFFD, 2, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
